fetch_ctrl: RTL and testbench

Sequences the instruction cycle of the 18-bit CPU and owns the program counter (PC).
- Fetches each instruction from program memory over a req/ack handshake and holds the fetched word.
- Pulses the instruction-register load strobe, starts the execute phase, and waits for the datapath to report completion.
- Then advances the PC or redirects it on a jump.
- Sits between program memory, the instruction register and the execute/datapath control.

---
 rtl/cpu_pkg.sv | 16 +
 rtl/fetch_ctrl.sv | 111 +++++++++++
 tb/tb_fetch_ctrl.sv | 294 +++++++++++++++++++++++++++++
 3 files changed

// File: rtl/cpu_pkg.sv
// Shared constants and types for the 18-bit CPU control path.
package cpu_pkg;

    localparam int unsigned INST_W       = 18;
    localparam int unsigned DEFAULT_PC_W = 12;
    localparam int unsigned DEFAULT_RESET_PC = 0;

    typedef enum logic [2:0] {
        IDLE,
        FETCH,
        LOAD,
        EXEC,
        ERR
    } fetch_state_t;

endpackage

// File: rtl/fetch_ctrl.sv
// Instruction-cycle sequencer: fetches over req/ack, strobes the IR, runs execute, owns the PC.
// All outputs are decoded from registered state.
module fetch_ctrl
    import cpu_pkg::*;
#(
    parameter int unsigned PC_W          = DEFAULT_PC_W,
    parameter int unsigned RESET_PC      = DEFAULT_RESET_PC,
    parameter int unsigned FETCH_TIMEOUT = 15
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              run_i,
    output logic              imem_req_o,
    output logic [PC_W-1:0]   imem_addr_o,
    input  logic              imem_ack_i,
    input  logic [INST_W-1:0] imem_data_i,
    output logic              ir_load_o,
    output logic [INST_W-1:0] ir_data_o,
    output logic              exec_start_o,
    input  logic              exec_done_i,
    input  logic              jump_i,
    input  logic [PC_W-1:0]   jump_addr_i,
    output logic [PC_W-1:0]   pc_o,
    output logic [15:0]       retired_o,
    output logic              busy_o,
    output logic              fetch_err_o
);

    // Last count value that may still be followed by an ack before giving up.
    localparam logic [7:0] TO_LAST = 8'(FETCH_TIMEOUT - 1);

    fetch_state_t      state_q, state_d;
    logic [PC_W-1:0]   pc_q, pc_d;
    logic [INST_W-1:0] ir_q, ir_d;
    logic [15:0]       ret_q, ret_d;
    logic [7:0]        cnt_q, cnt_d;
    logic              exec_first_q;

    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        ir_d    = ir_q;
        ret_d   = ret_q;
        cnt_d   = cnt_q;
        case (state_q)
            IDLE: begin
                if (run_i) begin
                    state_d = FETCH;
                end
            end
            FETCH: begin
                // An ack in the timeout cycle still completes the fetch.
                if (imem_ack_i) begin
                    ir_d    = imem_data_i;
                    cnt_d   = 8'd0;
                    state_d = LOAD;
                end else if (cnt_q == TO_LAST) begin
                    cnt_d   = 8'd0;
                    state_d = ERR;
                end else begin
                    cnt_d = cnt_q + 8'd1;
                end
            end
            LOAD: begin
                state_d = EXEC;
            end
            EXEC: begin
                if (exec_done_i) begin
                    pc_d    = jump_i ? jump_addr_i : pc_q + PC_W'(1);
                    ret_d   = ret_q + 16'd1;
                    state_d = run_i ? FETCH : IDLE;
                end
            end
            ERR: begin
                state_d = ERR;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= IDLE;
            pc_q         <= PC_W'(RESET_PC);
            ir_q         <= '0;
            ret_q        <= '0;
            cnt_q        <= '0;
            exec_first_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            pc_q         <= pc_d;
            ir_q         <= ir_d;
            ret_q        <= ret_d;
            cnt_q        <= cnt_d;
            exec_first_q <= (state_q == LOAD);
        end
    end

    assign imem_req_o   = (state_q == FETCH);
    assign imem_addr_o  = pc_q;
    assign ir_load_o    = (state_q == LOAD);
    assign ir_data_o    = ir_q;
    assign exec_start_o = (state_q == EXEC) && exec_first_q;
    assign pc_o         = pc_q;
    assign retired_o    = ret_q;
    assign busy_o       = (state_q == FETCH) || (state_q == LOAD) || (state_q == EXEC);
    assign fetch_err_o  = (state_q == ERR);

endmodule

// File: tb/tb_fetch_ctrl.sv
// Directed self-checking bench for fetch_ctrl.
module tb_fetch_ctrl;

    logic        clk = 1'b0;
    logic        rst;
    logic        run_i;
    logic        imem_req_o;
    logic [11:0] imem_addr_o;
    logic        imem_ack_i;
    logic [17:0] imem_data_i;
    logic        ir_load_o;
    logic [17:0] ir_data_o;
    logic        exec_start_o;
    logic        exec_done_i;
    logic        jump_i;
    logic [11:0] jump_addr_i;
    logic [11:0] pc_o;
    logic [15:0] retired_o;
    logic        busy_o;
    logic        fetch_err_o;

    int n_cmp  = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    fetch_ctrl #(
        .PC_W          (12),
        .RESET_PC      (0),
        .FETCH_TIMEOUT (15)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .run_i        (run_i),
        .imem_req_o   (imem_req_o),
        .imem_addr_o  (imem_addr_o),
        .imem_ack_i   (imem_ack_i),
        .imem_data_i  (imem_data_i),
        .ir_load_o    (ir_load_o),
        .ir_data_o    (ir_data_o),
        .exec_start_o (exec_start_o),
        .exec_done_i  (exec_done_i),
        .jump_i       (jump_i),
        .jump_addr_i  (jump_addr_i),
        .pc_o         (pc_o),
        .retired_o    (retired_o),
        .busy_o       (busy_o),
        .fetch_err_o  (fetch_err_o)
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1; run_i = 1'b0; imem_ack_i = 1'b0; imem_data_i = '0;
        exec_done_i = 1'b0; jump_i = 1'b0; jump_addr_i = '0;
        step();
        rst = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1; run_i = 1'b1; imem_ack_i = 1'b1; imem_data_i = 18'h3FFFF;
        exec_done_i = 1'b1; jump_i = 1'b1; jump_addr_i = 12'hABC;
        step();
        step();
        n_cmp++;
        if ({imem_req_o, ir_load_o, exec_start_o, busy_o, fetch_err_o} !== 5'b0) begin
            n_fail++;
            $display("FAIL reset_strobes: got %b want 00000",
                     {imem_req_o, ir_load_o, exec_start_o, busy_o, fetch_err_o});
        end
        n_cmp++;
        if (pc_o !== 12'h000 || retired_o !== 16'h0 || ir_data_o !== 18'h0) begin
            n_fail++;
            $display("FAIL reset_regs: got pc=%h ret=%h ir=%h want 000/0000/00000",
                     pc_o, retired_o, ir_data_o);
        end
        rst = 1'b0;
    endtask

    task automatic test_zero_wait();
        do_reset();
        run_i = 1'b1; imem_ack_i = 1'b1; exec_done_i = 1'b1;
        for (int i = 0; i < 3; i++) begin
            imem_data_i = 18'h30000 + 18'(i);
            step();
            n_cmp++;
            if (imem_req_o !== 1'b1 || imem_addr_o !== 12'(i)) begin
                n_fail++;
                $display("FAIL zw_fetch[%0d]: got req=%b addr=%h want 1/%h",
                         i, imem_req_o, imem_addr_o, 12'(i));
            end
            step();
            n_cmp++;
            if (ir_load_o !== 1'b1 || imem_req_o !== 1'b0 || ir_data_o !== 18'h30000 + 18'(i)) begin
                n_fail++;
                $display("FAIL zw_load[%0d]: got ld=%b req=%b ir=%h want 1/0/%h",
                         i, ir_load_o, imem_req_o, ir_data_o, 18'h30000 + 18'(i));
            end
            step();
            n_cmp++;
            if (exec_start_o !== 1'b1 || ir_load_o !== 1'b0 || busy_o !== 1'b1) begin
                n_fail++;
                $display("FAIL zw_exec[%0d]: got start=%b ld=%b busy=%b want 1/0/1",
                         i, exec_start_o, ir_load_o, busy_o);
            end
        end
        step();
        n_cmp++;
        if (retired_o !== 16'd3 || pc_o !== 12'd3 || imem_req_o !== 1'b1) begin
            n_fail++;
            $display("FAIL zw_retired: got ret=%0d pc=%h req=%b want 3/003/1",
                     retired_o, pc_o, imem_req_o);
        end
    endtask

    task automatic test_wait_states();
        do_reset();
        run_i = 1'b1; imem_ack_i = 1'b1; exec_done_i = 1'b1;
        jump_i = 1'b1; jump_addr_i = 12'h005;
        step(); step(); step();
        imem_ack_i = 1'b0;
        step();
        jump_i = 1'b0;
        for (int k = 1; k <= 5; k++) begin
            if (k == 5) begin
                imem_ack_i = 1'b1; imem_data_i = 18'h2A5F3;
            end
            n_cmp++;
            if (imem_req_o !== 1'b1 || imem_addr_o !== 12'h005) begin
                n_fail++;
                $display("FAIL ws_hold[%0d]: got req=%b addr=%h want 1/005",
                         k, imem_req_o, imem_addr_o);
            end
            step();
        end
        n_cmp++;
        if (ir_load_o !== 1'b1 || imem_req_o !== 1'b0 || ir_data_o !== 18'h2A5F3) begin
            n_fail++;
            $display("FAIL ws_load: got ld=%b req=%b ir=%h want 1/0/2a5f3",
                     ir_load_o, imem_req_o, ir_data_o);
        end
    endtask

    task automatic test_jump_wrap();
        do_reset();
        run_i = 1'b1; imem_ack_i = 1'b1; exec_done_i = 1'b1;
        jump_i = 1'b1; jump_addr_i = 12'hFFF;
        step(); step(); step(); step();
        jump_i = 1'b0;
        n_cmp++;
        if (imem_req_o !== 1'b1 || imem_addr_o !== 12'hFFF) begin
            n_fail++;
            $display("FAIL jw_jump: got req=%b addr=%h want 1/fff", imem_req_o, imem_addr_o);
        end
        step(); step(); step();
        n_cmp++;
        if (imem_req_o !== 1'b1 || imem_addr_o !== 12'h000 || retired_o !== 16'd2) begin
            n_fail++;
            $display("FAIL jw_wrap: got req=%b addr=%h ret=%0d want 1/000/2",
                     imem_req_o, imem_addr_o, retired_o);
        end
    endtask

    task automatic test_timeout();
        do_reset();
        run_i = 1'b1;
        step();
        for (int k = 1; k <= 15; k++) begin
            n_cmp++;
            if (imem_req_o !== 1'b1 || fetch_err_o !== 1'b0) begin
                n_fail++;
                $display("FAIL to_wait[%0d]: got req=%b err=%b want 1/0", k, imem_req_o, fetch_err_o);
            end
            step();
        end
        n_cmp++;
        if (fetch_err_o !== 1'b1 || imem_req_o !== 1'b0 || busy_o !== 1'b0) begin
            n_fail++;
            $display("FAIL to_err: got err=%b req=%b busy=%b want 1/0/0",
                     fetch_err_o, imem_req_o, busy_o);
        end
        imem_ack_i = 1'b1; exec_done_i = 1'b1;
        step(); step(); step();
        n_cmp++;
        if (fetch_err_o !== 1'b1 || imem_req_o !== 1'b0 || ir_load_o !== 1'b0) begin
            n_fail++;
            $display("FAIL to_sticky: got err=%b req=%b ld=%b want 1/0/0",
                     fetch_err_o, imem_req_o, ir_load_o);
        end
        do_reset();
        n_cmp++;
        if (fetch_err_o !== 1'b0 || pc_o !== 12'h000) begin
            n_fail++;
            $display("FAIL to_clear: got err=%b pc=%h want 0/000", fetch_err_o, pc_o);
        end
        // Ack on the final allowed cycle must still load.
        run_i = 1'b1;
        step();
        for (int k = 1; k < 15; k++) step();
        imem_ack_i = 1'b1; imem_data_i = 18'h1BEEF;
        step();
        n_cmp++;
        if (ir_load_o !== 1'b1 || fetch_err_o !== 1'b0 || ir_data_o !== 18'h1BEEF) begin
            n_fail++;
            $display("FAIL to_late_ack: got ld=%b err=%b ir=%h want 1/0/1beef",
                     ir_load_o, fetch_err_o, ir_data_o);
        end
    endtask

    task automatic test_stop_boundary();
        do_reset();
        run_i = 1'b1; imem_ack_i = 1'b1; exec_done_i = 1'b1;
        jump_i = 1'b1; jump_addr_i = 12'h007;
        step(); step(); step(); step();
        jump_i = 1'b0; exec_done_i = 1'b0;
        step(); step();
        run_i = 1'b0;
        step();
        n_cmp++;
        if (exec_start_o !== 1'b0 || busy_o !== 1'b1 || pc_o !== 12'h007) begin
            n_fail++;
            $display("FAIL sb_exec_wait: got start=%b busy=%b pc=%h want 0/1/007",
                     exec_start_o, busy_o, pc_o);
        end
        step();
        exec_done_i = 1'b1;
        step();
        n_cmp++;
        if (pc_o !== 12'h008 || busy_o !== 1'b0 || imem_req_o !== 1'b0) begin
            n_fail++;
            $display("FAIL sb_stop: got pc=%h busy=%b req=%b want 008/0/0", pc_o, busy_o, imem_req_o);
        end
        step();
        n_cmp++;
        if (imem_req_o !== 1'b0) begin
            n_fail++;
            $display("FAIL sb_idle: got req=%b want 0", imem_req_o);
        end
        run_i = 1'b1;
        step();
        n_cmp++;
        if (imem_req_o !== 1'b1 || imem_addr_o !== 12'h008) begin
            n_fail++;
            $display("FAIL sb_resume: got req=%b addr=%h want 1/008", imem_req_o, imem_addr_o);
        end
    endtask

    task automatic test_reset_mid();
        do_reset();
        run_i = 1'b1; imem_ack_i = 1'b1; exec_done_i = 1'b1;
        jump_i = 1'b1; jump_addr_i = 12'h009;
        step(); step(); step();
        imem_ack_i = 1'b0;
        step();
        jump_i = 1'b0;
        n_cmp++;
        if (imem_req_o !== 1'b1 || pc_o !== 12'h009 || retired_o !== 16'd1) begin
            n_fail++;
            $display("FAIL rm_setup: got req=%b pc=%h ret=%0d want 1/009/1",
                     imem_req_o, pc_o, retired_o);
        end
        rst = 1'b1; imem_ack_i = 1'b1;
        step();
        n_cmp++;
        if (imem_req_o !== 1'b0 || pc_o !== 12'h000 || retired_o !== 16'd0 || busy_o !== 1'b0) begin
            n_fail++;
            $display("FAIL rm_reset: got req=%b pc=%h ret=%0d busy=%b want 0/000/0/0",
                     imem_req_o, pc_o, retired_o, busy_o);
        end
        rst = 1'b0;
    endtask

    initial begin
        test_reset();
        test_zero_wait();
        test_wait_states();
        test_jump_wrap();
        test_timeout();
        test_stop_boundary();
        test_reset_mid();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1);
    end

endmodule
